// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch unit with a small prefetch queue
//
// Purpose: keeps a fetch PC, issues one instruction-memory request at a time,
// buffers returned words with their pc+4 in a DEPTH-entry FIFO and presents the
// head to the decode register. Redirects flush the queue and retarget the PC.
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   DEPTH      queue entries (power of two, 2..8)
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   enable                         stall from hazard unit (1 = hold head)
//   branch/jump/jump_reg + *_addr  redirect requests and targets
//   imem_req/imem_addr             request to instruction memory
//   imem_ack/imem_rdata            response from instruction memory
//   instr/pc_plus_4/instr_valid    queue head to decode
//
// Optional feature: define FETCH_BYPASS_EN to forward an acked word straight
// to decode when the queue is empty.

module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        branch,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic [31:0] branch_addr,
   input  logic [31:0] jump_addr,
   input  logic [31:0] jump_reg_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc_plus_4,
   output logic        instr_valid
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

   state_e          state_q;
   logic            imem_req_q;
   logic [31:0]     fpc_q;
   logic [CW-1:0]   count_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [31:0]     instr_mem_q [DEPTH];
   logic [31:0]     pc4_mem_q   [DEPTH];

   logic            redirect;
   logic [31:0]     fpc_d;
   logic [31:0]     fpc_plus_4;
   logic            ack_in_wait;
   logic            push;
   logic            pop_fifo;

   assign fpc_plus_4 = fpc_q + 32'd4;
   assign redirect   = jump_reg | jump | branch;

   // jump_reg has highest priority, then jump, then branch
   always_comb begin
      fpc_d = branch_addr;
      if (jump_reg) begin
         fpc_d = jump_reg_addr;
      end else if (jump) begin
         fpc_d = jump_addr;
      end
   end

   // an ack racing a redirect belongs to the old path and is dropped
   assign ack_in_wait = (state_q == WAIT) && imem_ack && !redirect;
   assign pop_fifo    = (count_q != '0) && !enable && !redirect;

`ifdef FETCH_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit = ack_in_wait && (count_q == '0) && !reset;
   // a bypassed word that decode takes this cycle must not also be queued
   assign push       = ack_in_wait && !(bypass_hit && !enable);
`else
   assign push       = ack_in_wait;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         imem_req_q <= 1'b0;
         fpc_q      <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else if (redirect) begin
         fpc_q    <= fpc_d;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         imem_req_q <= 1'b0;
         case (state_q)
            WAIT:    state_q <= DRAIN;
            DRAIN:   state_q <= imem_ack ? IDLE : DRAIN;
            default: state_q <= IDLE;
         endcase
      end else begin
         if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc4_mem_q[wr_ptr_q]   <= fpc_plus_4;
            wr_ptr_q              <= wr_ptr_q + 1'b1;
         end
         if (pop_fifo) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop_fifo})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         case (state_q)
            IDLE: begin
               // nothing is outstanding in IDLE, so count alone bounds occupancy
               if (count_q < DEPTH_C) begin
                  state_q    <= WAIT;
                  imem_req_q <= 1'b1;
               end
            end
            WAIT: begin
               if (imem_ack) begin
                  state_q    <= IDLE;
                  imem_req_q <= 1'b0;
                  fpc_q      <= fpc_plus_4;
               end
            end
            DRAIN: begin
               imem_req_q <= 1'b0;
               if (imem_ack) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               imem_req_q <= 1'b0;
            end
         endcase
      end
   end

   // fpc only changes on ack or redirect, so it is stable for a whole WAIT
   assign imem_req  = imem_req_q;
   assign imem_addr = fpc_q;

   always_comb begin
      instr       = 32'h0;
      pc_plus_4   = fpc_plus_4;
      instr_valid = 1'b0;
      if (count_q != '0) begin
         instr       = instr_mem_q[rd_ptr_q];
         pc_plus_4   = pc4_mem_q[rd_ptr_q];
         instr_valid = 1'b1;
      end
`ifdef FETCH_BYPASS_EN
      else if (bypass_hit) begin
         instr       = imem_rdata;
         pc_plus_4   = fpc_plus_4;
         instr_valid = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue

module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset, enable, branch, jump, jump_reg;
   logic [31:0] branch_addr, jump_addr, jump_reg_addr;
   logic        imem_req, imem_ack, instr_valid;
   logic [31:0] imem_addr, imem_rdata, instr, pc_plus_4;

   logic        reset2, enable2, imem_req2, imem_ack2, instr_valid2;
   logic [31:0] imem_addr2, imem_rdata2, instr2, pc_plus_42;

   logic        auto_ack, auto_ack2;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   fetch_queue #(.RESET_PC(32'h0040_0000), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .branch(branch), .jump(jump), .jump_reg(jump_reg),
      .branch_addr(branch_addr), .jump_addr(jump_addr), .jump_reg_addr(jump_reg_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .pc_plus_4(pc_plus_4), .instr_valid(instr_valid)
   );

   fetch_queue #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) dut_wrap (
      .clk(clk), .reset(reset2), .enable(enable2),
      .branch(1'b0), .jump(1'b0), .jump_reg(1'b0),
      .branch_addr(32'h0), .jump_addr(32'h0), .jump_reg_addr(32'h0),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
      .instr(instr2), .pc_plus_4(pc_plus_42), .instr_valid(instr_valid2)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock; the memory model answers any visible request in the same cycle
   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_ack) begin
         imem_ack   = imem_req;
         imem_rdata = word_at(imem_addr);
      end
      if (auto_ack2) begin
         imem_ack2   = imem_req2;
         imem_rdata2 = word_at(imem_addr2);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},   imem_req,    32'h0);
      chk({tag, "_addr"},  imem_addr,   32'h0040_0000);
      chk({tag, "_instr"}, instr,       32'h0);
      chk({tag, "_pc4"},   pc_plus_4,   32'h0040_0004);
      chk({tag, "_valid"}, instr_valid, 32'h0);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; branch = 1'b0; jump = 1'b0; jump_reg = 1'b0;
      branch_addr = 32'h0; jump_addr = 32'h0; jump_reg_addr = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0; auto_ack = 1'b0;
      reset2 = 1'b1; enable2 = 1'b0; imem_ack2 = 1'b0; imem_rdata2 = 32'h0; auto_ack2 = 1'b0;

      // reset state
      repeat (3) tick();
      chk_reset_outputs("rst");

      // sequential fetch, ack in the first WAIT cycle
      reset = 1'b0; auto_ack = 1'b1;
      tick();
      chk("seq_req0", imem_req, 32'h1);
      chk("seq_addr0", imem_addr, 32'h0040_0000);
      chk("seq_valid_before_push", instr_valid, 32'h0);
      tick();
      chk("seq_valid1", instr_valid, 32'h1);
      chk("seq_instr1", instr, word_at(32'h0040_0000));
      chk("seq_pc4_1", pc_plus_4, 32'h0040_0004);
      tick();
      chk("seq_addr1", imem_addr, 32'h0040_0004);
      chk("seq_req1", imem_req, 32'h1);

      // stall 10 cycles: queue fills to DEPTH and requests stop
      repeat (10) tick();
      chk("full_req_low", imem_req, 32'h0);
      chk("full_head", instr, word_at(32'h0040_0000));
      chk("full_valid", instr_valid, 32'h1);

      // drain the queue to prove exactly four entries were held
      auto_ack = 1'b0; enable = 1'b0;
      tick();
      chk("drain_head1", instr, word_at(32'h0040_0004));
      tick();
      chk("drain_head2", instr, word_at(32'h0040_0008));
      chk("drain_req", imem_req, 32'h1);
      chk("drain_req_addr", imem_addr, 32'h0040_0010);
      tick();
      chk("drain_head3", instr, word_at(32'h0040_000C));
      tick();
      chk("drain_empty", instr_valid, 32'h0);
      chk("drain_empty_pc4", pc_plus_4, 32'h0040_0014);

      // jump_reg while WAIT, late ack must be discarded
      jump_reg = 1'b1; jump_reg_addr = 32'h0040_0040;
      tick();
      jump_reg = 1'b0;
      chk("jr_req_low", imem_req, 32'h0);
      chk("jr_pc4", pc_plus_4, 32'h0040_0044);
      chk("jr_valid", instr_valid, 32'h0);
      tick();
      tick();
      chk("jr_drain_req", imem_req, 32'h0);
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      tick();
      imem_ack = 1'b0;
      chk("jr_stale_valid", instr_valid, 32'h0);
      chk("jr_stale_instr", instr, 32'h0);
      tick();
      chk("jr_new_req", imem_req, 32'h1);
      chk("jr_new_addr", imem_addr, 32'h0040_0040);

      // jump and branch together: jump wins, queue flushed
      enable = 1'b1;
      imem_ack = 1'b1; imem_rdata = word_at(32'h0040_0040);
      tick();
      imem_ack = 1'b0;
      chk("jb_pre_valid", instr_valid, 32'h1);
      chk("jb_pre_instr", instr, word_at(32'h0040_0040));
      jump = 1'b1; branch = 1'b1; jump_addr = 32'h0040_0100; branch_addr = 32'h0040_0200;
      tick();
      jump = 1'b0; branch = 1'b0;
      chk("jb_flush_valid", instr_valid, 32'h0);
      chk("jb_pc4", pc_plus_4, 32'h0040_0104);
      chk("jb_req_low", imem_req, 32'h0);
      tick();
      chk("jb_req", imem_req, 32'h1);
      chk("jb_addr", imem_addr, 32'h0040_0100);

      // reset mid-WAIT with a coincident ack
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      chk_reset_outputs("rst_wait");
      reset = 1'b0;
      tick();
      chk("rst_ack_ignored", instr_valid, 32'h0);
      chk("rst_first_req", imem_req, 32'h1);
      chk("rst_first_addr", imem_addr, 32'h0040_0000);
      imem_ack = 1'b1; imem_rdata = word_at(32'h0040_0000);

      // simultaneous push and pop keeps count
      auto_ack = 1'b1;
      tick();
      tick();
      tick();
      tick();
      enable = 1'b0;
      tick();
      chk("pp_head", instr, word_at(32'h0040_0004));
      chk("pp_valid", instr_valid, 32'h1);
      auto_ack = 1'b0;
      tick();
      chk("pp_head2", instr, word_at(32'h0040_0008));
      chk("pp_pc4_2", pc_plus_4, 32'h0040_000C);
      tick();
      chk("pp_empty", instr_valid, 32'h0);

      // PC wrap from 0xFFFF_FFFC
      chk("wrap_rst_pc4", pc_plus_42, 32'h0000_0000);
      chk("wrap_rst_addr", imem_addr2, 32'hFFFF_FFFC);
      reset2 = 1'b0; auto_ack2 = 1'b1;
      tick();
      chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
      tick();
      chk("wrap_head_pc4", pc_plus_42, 32'h0000_0000);
      chk("wrap_head_valid", instr_valid2, 32'h1);
      tick();
      chk("wrap_addr1", imem_addr2, 32'h0000_0000);
      chk("wrap_req1", imem_req2, 32'h1);
      chk("wrap_empty_pc4", pc_plus_42, 32'h0000_0004);
      tick();
      chk("wrap_instr2", instr2, word_at(32'h0000_0000));
      chk("wrap_pc4_2", pc_plus_42, 32'h0000_0004);
      chk("wrap_valid2", instr_valid2, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
